// File: rtl/raw_from_32.sv
// raw_from_32 -- unpacks a 32-bit word stream into 16-bit output samples.
//
// The input carries either 16-bit halves or packed 10-bit pixels. In packed
// mode a group is up to 4 MSB words (one byte per pixel, pixel bits 9:2)
// followed by one LSB word (two bits per pixel, pixel bits 1:0). A group
// shorter than 16 pixels is closed by ROW_END. In that case the last buffered
// word is reused as the LSB word, and its low-order pixel fields are
// left-aligned in the top 2n bits.
//
// Ports
//   clk, resetb      : clock (rising edge), async active-low reset
//   datai/dvi/dtypei : input word, valid, dtype
//   pack             : 1 = packed 10-bit, 0 = 16-bit halves (per accepted word)
//   rdy              : combinational, high in IDLE; accept = dvi && rdy
//   datao/dvo/dtypeo : registered output sample, single-cycle valid, dtype
//   image_type       : registered header field captured at half index
//                      `Image_image_type
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h0F
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h01
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h20
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h40
`endif
`ifndef Image_image_type
`define Image_image_type 5
`endif

module raw_from_32 #(
    parameter int PIXEL_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic [31:0]             datai,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic                    pack,
    output logic                    rdy,
    output logic [15:0]             datao,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]             image_type
);

    localparam int DW = `DTYPE_WIDTH;
    localparam logic [DW-1:0] DT_PIXEL   = `DTYPE_PIXEL;
    localparam logic [DW-1:0] DT_ROW_END = `DTYPE_ROW_END;
    localparam logic [DW-1:0] DT_HEADER  = `DTYPE_HEADER;
    localparam logic [DW-1:0] DT_PMASK   = `DTYPE_PIXEL_MASK;
    localparam logic [7:0]    HDR_IDX    = 8'(`Image_image_type);

    typedef enum logic [1:0] {IDLE, EMIT, END} state_t;

    state_t          state;
    logic [3:0][31:0] msb_buf;
    logic [2:0]      wcnt;
    logic [7:0]      hpos;
    logic [31:0]     lsb_word;     // right-aligned: pixel k uses bits 2k+1:2k
    logic [3:0]      pidx;
    logic [3:0]      plast;
    logic            half_mode;    // EMIT drains the upper half, not pixels
    logic            row_end_pend; // partial group: ROW_END follows the pixels
    logic [15:0]     hi_half;
    logic [DW-1:0]   dtype_hold;

    logic            accept, is_hdr, is_pix, is_end;
    logic [1:0]      widx;
    logic [5:0]      part_sh;
    logic [31:0]     part_lsb;

    assign rdy    = (state == IDLE);
    assign accept = dvi && rdy;
    assign is_hdr = (dtypei == DT_HEADER);
    assign is_pix = |(dtypei & DT_PMASK);
    assign is_end = (dtypei == DT_ROW_END);

    // Partial group of n = 4(w-1) pixels: the LSB fields sit in the top 2n
    // bits of buf[w-1]. A shift by 32-2n = 8(5-w) right-aligns them so that
    // both the full and the partial group use the same pixel indexing.
    assign widx     = 2'(wcnt - 3'd1);
    assign part_sh  = {3'(3'd5 - wcnt), 3'b000};
    assign part_lsb = msb_buf[widx] >> part_sh;

    function automatic logic [PIXEL_WIDTH-1:0] pixel_at(
        input logic [3:0][31:0] mb,
        input logic [31:0]      lw,
        input logic [3:0]       k
    );
        return {mb[k[3:2]][{k[1:0], 3'b000} +: 8], lw[{k, 1'b0} +: 2]};
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            msb_buf      <= '0;
            wcnt         <= '0;
            hpos         <= '0;
            lsb_word     <= '0;
            pidx         <= '0;
            plast        <= '0;
            half_mode    <= 1'b0;
            row_end_pend <= 1'b0;
            hi_half      <= '0;
            dtype_hold   <= '0;
            datao        <= '0;
            dvo          <= 1'b0;
            dtypeo       <= '0;
            image_type   <= '0;
        end else begin
            dvo <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_hdr || (is_pix && !pack)) begin
                        // 16-bit halves: low half now, high half from EMIT
                        datao      <= datai[15:0];
                        dvo        <= 1'b1;
                        dtypeo     <= dtypei;
                        hi_half    <= datai[31:16];
                        dtype_hold <= dtypei;
                        half_mode  <= 1'b1;
                        state      <= EMIT;
                        if (is_hdr) begin
                            if (hpos == HDR_IDX) image_type <= datai[15:0];
                            hpos <= hpos + 8'd1;
                        end else begin
                            hpos <= '0;
                        end
                    end else if (is_pix) begin
                        hpos <= '0;
                        if (wcnt != 3'd4) begin
                            msb_buf[wcnt[1:0]] <= datai;
                            wcnt               <= wcnt + 3'd1;
                        end else begin
                            // Full group: this word is the LSB word
                            wcnt         <= '0;
                            lsb_word     <= datai;
                            datao        <= 16'(pixel_at(msb_buf, datai, 4'd0));
                            dvo          <= 1'b1;
                            dtypeo       <= DT_PIXEL;
                            pidx         <= 4'd1;
                            plast        <= 4'd15;
                            half_mode    <= 1'b0;
                            row_end_pend <= 1'b0;
                            state        <= EMIT;
                        end
                    end else if (is_end) begin
                        hpos <= '0;
                        wcnt <= '0;
                        if (pack && wcnt >= 3'd2) begin
                            lsb_word     <= part_lsb;
                            datao        <= 16'(pixel_at(msb_buf, part_lsb, 4'd0));
                            dvo          <= 1'b1;
                            dtypeo       <= DT_PIXEL;
                            pidx         <= 4'd1;
                            plast        <= {2'(wcnt[1:0] - 2'd2), 2'b11};
                            half_mode    <= 1'b0;
                            row_end_pend <= 1'b1;
                            state        <= EMIT;
                        end else begin
                            // Empty group, or a lone word with no LSB partner
                            datao  <= '0;
                            dvo    <= 1'b1;
                            dtypeo <= DT_ROW_END;
                        end
                    end else begin
                        datao  <= datai[15:0];
                        dvo    <= 1'b1;
                        dtypeo <= dtypei;
                        wcnt   <= '0;
                        hpos   <= '0;
                    end
                end
                EMIT: begin
                    dvo <= 1'b1;
                    if (half_mode) begin
                        datao  <= hi_half;
                        dtypeo <= dtype_hold;
                        if (dtype_hold == DT_HEADER) begin
                            if (hpos == HDR_IDX) image_type <= hi_half;
                            hpos <= hpos + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        datao  <= 16'(pixel_at(msb_buf, lsb_word, pidx));
                        dtypeo <= DT_PIXEL;
                        pidx   <= pidx + 4'd1;
                        if (pidx == plast) state <= row_end_pend ? END : IDLE;
                    end
                end
                END: begin
                    datao  <= '0;
                    dvo    <= 1'b1;
                    dtypeo <= DT_ROW_END;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
